// File: rtl/countdown_timer_if.sv
// Control/preset/status bundle for countdown_timer.
// The timer connects through the slave modport; its driver uses master.
interface countdown_timer_if;
  logic       load;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic       start;
  logic       pause;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       expired;
  logic       load_err;

  modport master (
    output load, set_hours, set_minutes, set_seconds, start, pause,
    input  hours, minutes, seconds, running, expired, load_err
  );

  modport slave (
    input  load, set_hours, set_minutes, set_seconds, start, pause,
    output hours, minutes, seconds, running, expired, load_err
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable hh:mm:ss countdown timer on the 1 Hz time base, with a synchronous active-high reset.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload the preset at expiry.
module countdown_timer (
  input  logic             Clk_1sec,
  input  logic             reset,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  state_e     r_state, w_state_nxt;
  logic [4:0] r_hours, w_hours_nxt, r_pre_hours, w_pre_hours_nxt;
  logic [5:0] r_minutes, w_minutes_nxt, r_pre_minutes, w_pre_minutes_nxt;
  logic [5:0] r_seconds, w_seconds_nxt, r_pre_seconds, w_pre_seconds_nxt;
  logic       r_expired, w_expired_nxt;
  logic       r_load_err, w_load_err_nxt;

  logic w_set_ok, w_time_zero, w_time_one;

  assign w_set_ok    = (bus.set_hours <= 5'd23) && (bus.set_minutes <= 6'd59) &&
                       (bus.set_seconds <= 6'd59);
  assign w_time_zero = (r_hours == 5'd0) && (r_minutes == 6'd0) && (r_seconds == 6'd0);
  assign w_time_one  = (r_hours == 5'd0) && (r_minutes == 6'd0) && (r_seconds == 6'd1);

  always_comb begin
    w_state_nxt       = r_state;
    w_hours_nxt       = r_hours;
    w_minutes_nxt     = r_minutes;
    w_seconds_nxt     = r_seconds;
    w_pre_hours_nxt   = r_pre_hours;
    w_pre_minutes_nxt = r_pre_minutes;
    w_pre_seconds_nxt = r_pre_seconds;
    w_load_err_nxt    = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    w_expired_nxt     = 1'b0;
`else
    w_expired_nxt     = r_expired;
`endif

    if (bus.load) begin
      if (w_set_ok) begin
        w_hours_nxt       = bus.set_hours;
        w_minutes_nxt     = bus.set_minutes;
        w_seconds_nxt     = bus.set_seconds;
        w_pre_hours_nxt   = bus.set_hours;
        w_pre_minutes_nxt = bus.set_minutes;
        w_pre_seconds_nxt = bus.set_seconds;
        w_state_nxt       = StIdle;
        w_expired_nxt     = 1'b0;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (bus.pause && (r_state == StRun)) begin
      w_state_nxt = StPaused;
    end else if (bus.start && (((r_state == StIdle) && !w_time_zero) ||
                               (r_state == StPaused))) begin
      w_state_nxt = StRun;
    end else if (r_state == StRun) begin
      if (w_time_one) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        w_hours_nxt   = r_pre_hours;
        w_minutes_nxt = r_pre_minutes;
        w_seconds_nxt = r_pre_seconds;
        w_expired_nxt = 1'b1;
`else
        w_seconds_nxt = 6'd0;
        w_state_nxt   = StExpired;
        w_expired_nxt = 1'b1;
`endif
      end else if (r_seconds != 6'd0) begin
        w_seconds_nxt = r_seconds - 6'd1;
      end else begin
        // Borrow chain; time is nonzero here so hours never underflows.
        w_seconds_nxt = 6'd59;
        if (r_minutes != 6'd0) begin
          w_minutes_nxt = r_minutes - 6'd1;
        end else begin
          w_minutes_nxt = 6'd59;
          w_hours_nxt   = r_hours - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk_1sec) begin
    if (reset) begin
      r_state       <= StIdle;
      r_hours       <= 5'd0;
      r_minutes     <= 6'd0;
      r_seconds     <= 6'd0;
      r_pre_hours   <= 5'd0;
      r_pre_minutes <= 6'd0;
      r_pre_seconds <= 6'd0;
      r_expired     <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hours       <= w_hours_nxt;
      r_minutes     <= w_minutes_nxt;
      r_seconds     <= w_seconds_nxt;
      r_pre_hours   <= w_pre_hours_nxt;
      r_pre_minutes <= w_pre_minutes_nxt;
      r_pre_seconds <= w_pre_seconds_nxt;
      r_expired     <= w_expired_nxt;
      r_load_err    <= w_load_err_nxt;
    end
  end

  assign bus.hours    = r_hours;
  assign bus.minutes  = r_minutes;
  assign bus.seconds  = r_seconds;
  assign bus.running  = (r_state == StRun);
  assign bus.expired  = r_expired;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; the reload section needs
// COUNTDOWN_AUTO_RELOAD_EN defined for both bench and design.
module tb_countdown_timer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  countdown_timer_if u_if ();

  countdown_timer u_dut (
    .Clk_1sec (clk),
    .reset    (reset),
    .bus      (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    logic [31:0] exp;
    exp = {15'd0, h[4:0], m[5:0], s[5:0]};
    check(tag, {15'd0, u_if.hours, u_if.minutes, u_if.seconds}, exp);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    u_if.load        = 1'b1;
    u_if.set_hours   = h[4:0];
    u_if.set_minutes = m[5:0];
    u_if.set_seconds = s[5:0];
    step(1);
    u_if.load = 1'b0;
  endtask

  task automatic do_start();
    u_if.start = 1'b1;
    step(1);
    u_if.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    u_if.load = 1'b0;
    u_if.start = 1'b0;
    u_if.pause = 1'b0;
    u_if.set_hours = 5'd0;
    u_if.set_minutes = 6'd0;
    u_if.set_seconds = 6'd0;
    step(1);
    reset = 1'b0;

    // Reset state
    check_time("rst_time", 0, 0, 0);
    check("rst_running", {31'd0, u_if.running}, 32'd0);
    check("rst_expired", {31'd0, u_if.expired}, 32'd0);
    check("rst_load_err", {31'd0, u_if.load_err}, 32'd0);

    // Basic expiry from 00:01:05
    do_load(0, 1, 5);
    check_time("load_0105", 0, 1, 5);
    check("load_idle", {31'd0, u_if.running}, 32'd0);
    do_start();
    check("start_running", {31'd0, u_if.running}, 32'd1);
    check_time("start_no_dec", 0, 1, 5);
    step(5);
    check_time("at_0100", 0, 1, 0);
    step(1);
    check_time("min_borrow", 0, 0, 59);
    step(58);
    check_time("at_0001", 0, 0, 1);
    check("pre_exp", {31'd0, u_if.expired}, 32'd0);
    step(1);
    check_time("exp_time", 0, 0, 0);
    check("exp_flag", {31'd0, u_if.expired}, 32'd1);
    check("exp_running", {31'd0, u_if.running}, 32'd0);
    do_start();
    check("exp_start_ign", {31'd0, u_if.running}, 32'd0);
    check("exp_sticky", {31'd0, u_if.expired}, 32'd1);

    // Hour borrow
    do_load(1, 0, 0);
    check("load_clr_exp", {31'd0, u_if.expired}, 32'd0);
    do_start();
    step(1);
    check_time("hour_borrow", 0, 59, 59);

    // Pause and resume
    do_load(0, 0, 30);
    do_start();
    step(10);
    check_time("at_0020", 0, 0, 20);
    u_if.pause = 1'b1;
    step(1);
    u_if.pause = 1'b0;
    check("paused_running", {31'd0, u_if.running}, 32'd0);
    step(10);
    check_time("paused_hold", 0, 0, 20);
    do_start();
    check("resume_running", {31'd0, u_if.running}, 32'd1);
    check_time("resume_no_dec", 0, 0, 20);
    step(1);
    check_time("resume_dec", 0, 0, 19);
    u_if.start = 1'b1;
    u_if.pause = 1'b1;
    step(1);
    u_if.start = 1'b0;
    u_if.pause = 1'b0;
    check("pause_wins", {31'd0, u_if.running}, 32'd0);
    check_time("pause_wins_time", 0, 0, 19);

    // Load rejection and range boundaries
    do_load(0, 5, 0);
    do_load(24, 0, 0);
    check("rej_hours_err", {31'd0, u_if.load_err}, 32'd1);
    check_time("rej_hours_time", 0, 5, 0);
    step(1);
    check("rej_err_pulse", {31'd0, u_if.load_err}, 32'd0);
    do_load(0, 60, 0);
    check("rej_min_err", {31'd0, u_if.load_err}, 32'd1);
    do_load(0, 0, 60);
    check("rej_sec_err", {31'd0, u_if.load_err}, 32'd1);
    check_time("rej_sec_time", 0, 5, 0);
    do_load(23, 59, 59);
    check("max_ok_err", {31'd0, u_if.load_err}, 32'd0);
    check_time("max_ok_time", 23, 59, 59);
    do_load(0, 0, 0);
    do_start();
    check("zero_start_ign", {31'd0, u_if.running}, 32'd0);

    // Reset mid-run, discarding a simultaneous start and load
    do_load(0, 0, 50);
    do_start();
    step(10);
    check_time("at_0040", 0, 0, 40);
    reset = 1'b1;
    u_if.start = 1'b1;
    step(1);
    reset = 1'b0;
    u_if.start = 1'b0;
    check_time("midrun_rst_time", 0, 0, 0);
    check("midrun_rst_run", {31'd0, u_if.running}, 32'd0);
    reset = 1'b1;
    do_load(0, 0, 10);
    reset = 1'b0;
    check_time("rst_beats_load", 0, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    do_load(0, 0, 3);
    do_start();
    check_time("ar_start", 0, 0, 3);
    step(1);
    check_time("ar_02a", 0, 0, 2);
    step(1);
    check_time("ar_01a", 0, 0, 1);
    check("ar_noexp", {31'd0, u_if.expired}, 32'd0);
    step(1);
    check_time("ar_03a", 0, 0, 3);
    check("ar_exp_a", {31'd0, u_if.expired}, 32'd1);
    check("ar_run_a", {31'd0, u_if.running}, 32'd1);
    step(1);
    check_time("ar_02b", 0, 0, 2);
    check("ar_exp_pulse", {31'd0, u_if.expired}, 32'd0);
    step(1);
    check_time("ar_01b", 0, 0, 1);
    step(1);
    check_time("ar_03b", 0, 0, 3);
    check("ar_exp_b", {31'd0, u_if.expired}, 32'd1);
    check("ar_run_b", {31'd0, u_if.running}, 32'd1);
`else
    // A rejected load leaves the sticky expiry flag alone
    do_load(0, 0, 2);
    do_start();
    step(2);
    check("short_exp", {31'd0, u_if.expired}, 32'd1);
    do_load(30, 0, 0);
    check("rej_keeps_exp", {31'd0, u_if.expired}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
